// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scan controller
package keypad_pkg;
  typedef logic [3:0] keycode_t;
  typedef enum logic {DRIVE = 1'b0, SAMPLE = 1'b1} scan_state_e;
  localparam logic [0:0] ST_DRIVE  = 1'b0;
  localparam logic [0:0] ST_SAMPLE = 1'b1;
  localparam keycode_t KEY_P1_UP   = 4'd1;
  localparam keycode_t KEY_P1_DOWN = 4'd9;
  localparam keycode_t KEY_P2_UP   = 4'd3;
  localparam keycode_t KEY_P2_DOWN = 4'd7;
endpackage

// File: rtl/keypad_evt_arb.sv
// keypad_evt_arb: lowest-index pending picker feeding a valid/ready event register
// Ports: clk, rst_n (sync, active low); req pending mask, lvl press level per request,
//        evt_ready consumer accept; evt_valid/evt_code/evt_press event register,
//        clr one-hot of the request consumed this cycle.
// Request index i reports keycode i[3:0], so a 32-bit mask serves two 16-key sources.
module keypad_evt_arb
  import keypad_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] lvl,
  input  logic         evt_ready,
  output logic         evt_valid,
  output keycode_t     evt_code,
  output logic         evt_press,
  output logic [N-1:0] clr
);
  logic [N-1:0] hit;
  keycode_t     code;
  logic         press;
  logic         open;
  assign open = !evt_valid || evt_ready;
  always_comb begin
    hit   = '0;
    code  = '0;
    press = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
        code   = i[3:0];
        press  = lvl[i];
      end
    end
    clr = open ? hit : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_press <= 1'b0;
    end else if (open) begin
      evt_valid <= |req;
      if (|req) begin
        evt_code  <= code;
        evt_press <= press;
      end
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner, per-key debouncer and press/release event source
// Ports: clk, rst_n (sync, active low); row_in synchronised row sense; col_drive one-hot
//        column drive; key_state debounced levels; evt_valid/evt_ready/evt_code/evt_press
//        event port; p1_up/p1_down/p2_up/p2_down paddle levels.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (repeat press events for a single held key).
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_SCANS   = 50
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_drive,
  output logic [15:0] key_state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output keycode_t    evt_code,
  output logic        evt_press,
  output logic        p1_up,
  output logic        p1_down,
  output logic        p2_up,
  output logic        p2_down
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int NREQ = 32;
`else
  localparam int NREQ = 16;
`endif
  logic [0:0]       state;
  logic [SW-1:0]    settle_cnt;
  logic             settle_last;
  logic [1:0]       col;
  logic [15:0]      raw, raw_nxt;
  logic [15:0][2:0] cnt, cnt_nxt;
  logic [15:0]      ks_nxt, flip;
  logic [15:0]      pending, pending_nxt;
  logic             scan_end;
  logic [NREQ-1:0]  req, lvl, clr;
  assign settle_last = settle_cnt == SW'(SETTLE_CYCLES - 1);
  assign scan_end    = (state == ST_SAMPLE) && (col == 2'd3);
  assign col_drive   = 4'b0001 << col;
  assign p1_up       = key_state[KEY_P1_UP];
  assign p1_down     = key_state[KEY_P1_DOWN];
  assign p2_up       = key_state[KEY_P2_UP];
  assign p2_down     = key_state[KEY_P2_DOWN];
  // Debounce sees the column being latched this cycle, so a scan's decision covers all 16 keys.
  always_comb begin
    raw_nxt               = raw;
    raw_nxt[{col, 2'b00} +: 4] = row_in;
    ks_nxt                = key_state;
    flip                  = '0;
    cnt_nxt               = cnt;
    for (int k = 0; k < 16; k++) begin
      if (raw_nxt[k] != key_state[k]) begin
        if (cnt[k] == 3'(DEBOUNCE_SCANS - 1)) begin
          ks_nxt[k]  = ~key_state[k];
          flip[k]    = 1'b1;
          cnt_nxt[k] = '0;
        end else begin
          cnt_nxt[k] = cnt[k] + 3'd1;
        end
      end else begin
        cnt_nxt[k] = '0;
      end
    end
    // Clear-then-toggle: a flip landing on the key being loaded keeps it pending.
    pending_nxt = (pending & ~clr[15:0]) ^ (scan_end ? flip : 16'h0);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_DRIVE;
      settle_cnt <= '0;
      col        <= '0;
      raw        <= '0;
      key_state  <= '0;
      cnt        <= '0;
      pending    <= '0;
    end else begin
      pending <= pending_nxt;
      if (state == ST_DRIVE) begin
        settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
        if (settle_last) state <= ST_SAMPLE;
      end else begin
        state <= ST_DRIVE;
        col   <= col + 2'd1;
        raw   <= raw_nxt;
        if (col == 2'd3) begin
          key_state <= ks_nxt;
          cnt       <= cnt_nxt;
        end
      end
    end
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0] rpt_timer, rpt_timer_nxt, rpt_pend, rpt_set;
  always_comb begin
    rpt_timer_nxt = rpt_timer;
    rpt_set       = '0;
    if (scan_end) begin
      if ((|flip) || !$onehot(key_state)) begin
        rpt_timer_nxt = '0;
      end else if (rpt_timer == 16'(REPEAT_SCANS - 1)) begin
        rpt_timer_nxt = '0;
        rpt_set       = key_state;
      end else begin
        rpt_timer_nxt = rpt_timer + 16'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_timer <= '0;
      rpt_pend  <= '0;
    end else begin
      rpt_timer <= rpt_timer_nxt;
      rpt_pend  <= (rpt_pend & ~clr[31:16]) | rpt_set;
    end
  end
  // Repeat requests sit above the real flips in index, so flips win the priority encoder.
  assign req = {rpt_pend, pending};
  assign lvl = {16'hFFFF, key_state};
`else
  assign req = pending;
  assign lvl = key_state;
`endif
  keypad_evt_arb #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lvl       (lvl),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .clr       (clr)
  );
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl with a 4x4 matrix model (scan = 12 cycles)
module tb_keypad_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, evt_ready, evt_valid, evt_press;
  logic        p1_up, p1_down, p2_up, p2_down;
  logic [3:0]  row_in, col_drive, evt_code;
  logic [15:0] key_state;
  logic [15:0] pressed = 16'h0;
  int checks = 0, errors = 0, j = 0;
  always #5 clk = ~clk;
  keypad_scan_ctrl #(
    .SETTLE_CYCLES  (2),
    .DEBOUNCE_SCANS (2)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_SCANS   (3)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .p1_up     (p1_up),
    .p1_down   (p1_down),
    .p2_up     (p2_up),
    .p2_down   (p2_down)
  );
  always_comb begin
    row_in = '0;
    for (int c = 0; c < 4; c++) if (col_drive[c]) row_in = row_in | pressed[4*c +: 4];
  end
  task step(input int n);
    repeat (n) begin
      @(negedge clk);
      j++;
    end
  endtask
  task align;
    while (j % 12 != 0) step(1);
  endtask
  task test_reset;
    checks++; if (col_drive !== 4'b0001) begin errors++; $display("FAIL reset col_drive: got %b want 0001", col_drive); end
    checks++; if (key_state !== 16'h0) begin errors++; $display("FAIL reset key_state: got %h want 0000", key_state); end
    checks++; if ({evt_valid, evt_code, evt_press} !== 6'b0) begin errors++; $display("FAIL reset evt: got v%b c%h p%b want 0", evt_valid, evt_code, evt_press); end
    checks++; if ({p1_up, p1_down, p2_up, p2_down} !== 4'b0) begin errors++; $display("FAIL reset paddles: got %b want 0000", {p1_up, p1_down, p2_up, p2_down}); end
  endtask
  task test_scan_sequence;
    logic [3:0] exp_col;
    for (int i = 0; i < 120; i++) begin
      exp_col = 4'b0001 << ((i / 3) % 4);
      checks++; if (col_drive !== exp_col) begin errors++; $display("FAIL scan col_drive @%0d: got %b want %b", i, col_drive, exp_col); end
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL idle evt_valid @%0d: got %b want 0", i, evt_valid); end
      step(1);
    end
  endtask
  task test_press_release;
    align; pressed = 16'h0002; step(23);
    checks++; if (key_state !== 16'h0) begin errors++; $display("FAIL press early key_state: got %h want 0000", key_state); end
    step(1);
    checks++; if (key_state !== 16'h0002) begin errors++; $display("FAIL press key_state: got %h want 0002", key_state); end
    checks++; if ({p1_up, p1_down, p2_up, p2_down} !== 4'b1000) begin errors++; $display("FAIL press paddles: got %b want 1000", {p1_up, p1_down, p2_up, p2_down}); end
    step(1);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd1, 1'b1}) begin errors++; $display("FAIL press evt: got v%b c%0d p%b want v1 c1 p1", evt_valid, evt_code, evt_press); end
    step(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL press evt drained: got %b want 0", evt_valid); end
    align; pressed = 16'h0; step(23);
    checks++; if (key_state !== 16'h0002) begin errors++; $display("FAIL release early key_state: got %h want 0002", key_state); end
    step(1);
    checks++; if (key_state !== 16'h0 || p1_up !== 1'b0) begin errors++; $display("FAIL release key_state: got %h p1_up %b want 0000 0", key_state, p1_up); end
    step(1);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd1, 1'b0}) begin errors++; $display("FAIL release evt: got v%b c%0d p%b want v1 c1 p0", evt_valid, evt_code, evt_press); end
    step(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL release evt drained: got %b want 0", evt_valid); end
  endtask
  task test_bounce;
    logic seen;
    seen = 1'b0;
    align;
    for (int i = 0; i < 60; i++) begin
      pressed = (i < 12 || (i >= 24 && i < 36)) ? 16'h0200 : 16'h0;
      if (i == 36) begin
        checks++; if (key_state !== 16'h0 || p1_down !== 1'b0) begin errors++; $display("FAIL bounce mid key_state: got %h p1_down %b want 0000 0", key_state, p1_down); end
      end
      if (evt_valid) seen = 1'b1;
      step(1);
    end
    checks++; if (key_state !== 16'h0 || p1_down !== 1'b0) begin errors++; $display("FAIL bounce key_state: got %h p1_down %b want 0000 0", key_state, p1_down); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bounce event: got %b want 0", seen); end
  endtask
  task test_back_to_back;
    align; evt_ready = 1'b0; pressed = 16'h0088; step(24);
    checks++; if (key_state !== 16'h0088 || {p2_up, p2_down} !== 2'b11) begin errors++; $display("FAIL pair key_state: got %h p2 %b want 0088 11", key_state, {p2_up, p2_down}); end
    step(1);
    for (int i = 0; i < 21; i++) begin
      checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd3, 1'b1}) begin errors++; $display("FAIL stall hold @%0d: got v%b c%0d p%b want v1 c3 p1", i, evt_valid, evt_code, evt_press); end
      if (i < 20) step(1);
    end
    evt_ready = 1'b1; step(1);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd7, 1'b1}) begin errors++; $display("FAIL stall second: got v%b c%0d p%b want v1 c7 p1", evt_valid, evt_code, evt_press); end
    step(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL stall drained: got %b want 0", evt_valid); end
    align; pressed = 16'h0; step(25);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd3, 1'b0}) begin errors++; $display("FAIL b2b first: got v%b c%0d p%b want v1 c3 p0", evt_valid, evt_code, evt_press); end
    step(1);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd7, 1'b0}) begin errors++; $display("FAIL b2b second: got v%b c%0d p%b want v1 c7 p0", evt_valid, evt_code, evt_press); end
    step(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b drained: got %b want 0", evt_valid); end
  endtask
  task test_cancel;
    logic seen;
    align; evt_ready = 1'b0; pressed = 16'h0008; step(24);
    pressed = 16'h0808; step(24);
    checks++; if (key_state !== 16'h0808) begin errors++; $display("FAIL cancel press key_state: got %h want 0808", key_state); end
    pressed = 16'h0008; step(24);
    checks++; if (key_state !== 16'h0008) begin errors++; $display("FAIL cancel release key_state: got %h want 0008", key_state); end
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd3, 1'b1}) begin errors++; $display("FAIL cancel held evt: got v%b c%0d p%b want v1 c3 p1", evt_valid, evt_code, evt_press); end
    evt_ready = 1'b1; seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (evt_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel key11 event: got %b want 0", seen); end
  endtask
  task test_reset_mid_scan;
    align; evt_ready = 1'b0; pressed = 16'h0002; step(31);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd1, 1'b1}) begin errors++; $display("FAIL prereset evt: got v%b c%0d p%b want v1 c1 p1", evt_valid, evt_code, evt_press); end
    rst_n = 1'b0; step(1);
    checks++; if (col_drive !== 4'b0001) begin errors++; $display("FAIL midreset col_drive: got %b want 0001", col_drive); end
    checks++; if (key_state !== 16'h0 || p1_up !== 1'b0) begin errors++; $display("FAIL midreset key_state: got %h p1_up %b want 0000 0", key_state, p1_up); end
    checks++; if ({evt_valid, evt_code, evt_press} !== 6'b0) begin errors++; $display("FAIL midreset evt: got v%b c%h p%b want 0", evt_valid, evt_code, evt_press); end
    rst_n = 1'b1; evt_ready = 1'b1; j = 0; step(23);
    checks++; if (key_state !== 16'h0) begin errors++; $display("FAIL postreset early key_state: got %h want 0000", key_state); end
    step(1);
    checks++; if (key_state !== 16'h0002) begin errors++; $display("FAIL postreset key_state: got %h want 0002", key_state); end
    step(1);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd1, 1'b1}) begin errors++; $display("FAIL postreset evt: got v%b c%0d p%b want v1 c1 p1", evt_valid, evt_code, evt_press); end
    step(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL postreset drained: got %b want 0", evt_valid); end
`ifdef KEYPAD_AUTOREPEAT_EN
    step(35);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd1, 1'b1}) begin errors++; $display("FAIL repeat first: got v%b c%0d p%b want v1 c1 p1", evt_valid, evt_code, evt_press); end
    step(1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL repeat drained: got %b want 0", evt_valid); end
    step(35);
    checks++; if ({evt_valid, evt_code, evt_press} !== {1'b1, 4'd1, 1'b1}) begin errors++; $display("FAIL repeat second: got v%b c%0d p%b want v1 c1 p1", evt_valid, evt_code, evt_press); end
`endif
  endtask
  initial begin
    rst_n = 1'b0;
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    j = 0;
    test_scan_sequence;
    test_press_release;
    test_bounce;
    test_back_to_back;
    test_cancel;
    test_reset_mid_scan;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencer and event scheduler for the 4x4 matrix keypad that drives the Pong paddles. It walks the column drives with a programmable settle time and samples rows at the end of each column slot. It debounces all 16 keys per scan and serialises press/release events through a valid/ready port. It also presents level-held paddle controls for both players to the game logic.

Parameters:
SETTLE_CYCLES, 1000, cycles a column is driven before its rows are sampled (>=1)
DEBOUNCE_SCANS, 4, consecutive full scans a raw key level must differ from stable state before it flips (1..7)
REPEAT_SCANS, 50, scans between auto-repeat press events (only with KEYPAD_AUTOREPEAT_EN)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  synchronous, active-low reset
row_in  in  4  raw row sense, already synchronised; row_in[0] is matrix row 0
col_drive  out  4  one-hot column drive, active high
key_state  out  16  debounced key levels, bit k = keycode k
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event when evt_valid && evt_ready
evt_code  out  4  keycode of event
evt_press  out  1  1 = press, 0 = release
p1_up, p1_down, p2_up, p2_down  out  1 each  key_state[1], [9], [3], [7]

Behaviour:
- Keycode = {column[1:0], row[1:0]}. Column c drives col_drive = 1<<c.
- Scan FSM states: DRIVE and SAMPLE.
  - DRIVE counts SETTLE_CYCLES cycles, then moves to SAMPLE.
  - SAMPLE lasts 1 cycle. It latches row_in into raw[4c+3:4c] and advances c mod 4.
  - Each column slot is SETTLE_CYCLES+1 cycles; a full scan is 4*(SETTLE_CYCLES+1) cycles.
  - col_drive changes only on the cycle after SAMPLE.
- Scan end is the SAMPLE of column 3. On that cycle, for each key k:
  - if raw[k] != key_state[k], increment cnt[k] (3-bit); otherwise clear it.
  - when cnt[k] reaches DEBOUNCE_SCANS, key_state[k] toggles, cnt[k] clears, and pending[k] ^= 1.
- key_state and paddle outputs update one cycle after scan end and are glitch-free registered levels.
- Event scheduler:
  - Single output register. When !evt_valid or the current event is accepted, load the lowest-index k with pending[k].
  - Load sets evt_code = k and evt_press = key_state[k], then clears pending[k] in the same cycle.
  - One event loaded per cycle at most.
- Boundary cases:
  - Key flips twice before being served: the pending XOR cancels it and no event is emitted.
  - Load and toggle on the same key in the same cycle: the toggle wins and the bit stays pending with the new level.
  - evt_valid with !evt_ready: evt_code and evt_press are held stable. Scanning and debounce continue and pending accumulates; nothing is lost beyond one pending bit per key.
- Reset (any cycle, including mid-scan):
  - c = 0 and state DRIVE, so col_drive = 4'b0001.
  - Counters, raw, key_state, pending and cnt cleared.
  - evt_valid = 0, evt_code = 0, evt_press = 0, all paddle outputs 0.
  - First SAMPLE occurs SETTLE_CYCLES cycles after rst_n rises.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: a per-controller 16-bit repeat timer counts scans while exactly one key is stable-pressed. Every REPEAT_SCANS scans it sets pending-repeat for that key, which the scheduler emits as evt_press = 1, with priority below real flips. The timer resets on any key_state change.
- Undefined: no repeat logic, no extra registers, and REPEAT_SCANS is unused.

Decomposition:
- Package keypad_pkg:
  - keycode_t (4-bit) and scan state enum {DRIVE, SAMPLE}.
  - Constants KEY_P1_UP = 1, KEY_P1_DOWN = 9, KEY_P2_UP = 3, KEY_P2_DOWN = 7.
- Sub-module keypad_evt_arb: 16-bit pending mask in, lowest-index priority encoder plus output register with valid/ready. Reused for the repeat source.

Test Plan (SETTLE_CYCLES=2, DEBOUNCE_SCANS=2; scan = 12 cycles):
1. Reset release, rows 0 -> col_drive sequence 0001, 0010, 0100, 1000 (3 cycles each, repeating); no evt_valid for 10 scans.
2. Hold row 1 high only while column 0 is driven for 2 scans -> key_state[1] = 1 and p1_up = 1 one cycle after second scan end; event code 1 with press = 1. Release, then after 2 scans -> code 1 with press = 0.
3. Bounce: key 9 asserted for 1 scan, then dropped -> cnt clears, no event, p1_down stays 0.
4. Keys 3 and 7 pressed in the same scan, evt_ready held 0 for 20 cycles -> evt_code = 3 held stable. Raise ready -> code 3, then code 7 on consecutive cycles.
5. Key 11 press debounced with ready = 0, then released and debounced before ready -> pending cancels; no event for key 11 after ready rises.
6. rst_n low for 1 cycle mid-column 2 -> next cycle col_drive = 0001, key_state = 0, evt_valid = 0. With KEYPAD_AUTOREPEAT_EN and REPEAT_SCANS = 3: held key 1 gives a press event every 3 scans.
